// File: rtl/ahb_slave_decode_mux.sv
// AHB-Lite slave-side address decoder and data-phase response mux with a
// built-in default slave that answers unmapped accesses with a two-cycle ERROR.
module ahb_slave_decode_mux #(
    parameter int unsigned SLV_NUM = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned SEL_LSB = 16,
    parameter logic [31:0] BASE    = 32'h4000_0000
) (
    input  logic                   hclk,
    input  logic                   hrst_b,
    input  logic                   hsel,
    input  logic [31:0]            haddr,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    output logic [SLV_NUM-1:0]     s_hsel,
    input  logic [32*SLV_NUM-1:0]  s_hrdata,
    input  logic [SLV_NUM-1:0]     s_hready,
    input  logic [2*SLV_NUM-1:0]   s_hresp,
    output logic [31:0]            hrdata,
    output logic                   hready,
    output logic [1:0]             hresp,
    input  logic                   err_clr,
    output logic [7:0]             err_cnt,
    output logic                   err_intr
);

    localparam int unsigned TAG_LSB = SEL_LSB + SEL_W;

    typedef enum logic [1:0] {OWN_NONE, OWN_SLOT, OWN_DEF} own_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

    own_t             r_own;
    logic [SEL_W-1:0] r_own_idx;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_err_cnt;
    logic             r_err_intr;

    logic [SEL_W-1:0] w_idx;
    logic             w_hit;
    logic             w_req;
    logic             w_def_acc;
    logic             w_err_evt;
    logic             w_def_hready;
    logic [1:0]       w_def_hresp;
    logic             w_unused;

    // Write strobe and in-region offset play no part in decode.
    assign w_unused = ^{hwrite, htrans[0], haddr[SEL_LSB-1:0]};

    assign w_idx = haddr[TAG_LSB-1:SEL_LSB];
    assign w_hit = hsel
                 && (haddr[31:TAG_LSB] == BASE[31:TAG_LSB])
                 && (32'(w_idx) < SLV_NUM);
    assign w_req     = hsel & htrans[1];
    assign w_def_acc = hready & w_req & ~w_hit;

    always_comb begin
        s_hsel = '0;
        for (int i = 0; i < int'(SLV_NUM); i++) begin
            s_hsel[i] = w_hit && (w_idx == SEL_W'(i));
        end
    end

    // Default-slave Moore outputs, kept apart from next-state to avoid a hready loop.
    assign w_def_hready = (r_state != ST_ERR1);
    assign w_def_hresp  = (r_state == ST_IDLE) ? 2'b00 : 2'b01;

    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = 2'b00;
        case (r_own)
            OWN_SLOT: begin
                for (int i = 0; i < int'(SLV_NUM); i++) begin
                    if (r_own_idx == SEL_W'(i)) begin
                        hrdata = s_hrdata[32*i +: 32];
                        hready = s_hready[i];
                        hresp  = s_hresp[2*i +: 2];
                    end
                end
            end
            OWN_DEF: begin
                hready = w_def_hready;
                hresp  = w_def_hresp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_evt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_def_acc) begin
                    w_state_nxt = ST_ERR1;
                    w_err_evt   = 1'b1;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            ST_ERR2: begin
                if (w_def_acc) begin
                    w_state_nxt = ST_ERR1;
                    w_err_evt   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Data-phase owner is captured only when the current data phase completes.
    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            r_own     <= OWN_NONE;
            r_own_idx <= '0;
        end else if (hready) begin
            r_own_idx <= w_idx;
            if (!w_req) begin
                r_own <= OWN_NONE;
            end else if (w_hit) begin
                r_own <= OWN_SLOT;
            end else begin
                r_own <= OWN_DEF;
            end
        end
    end

    // A new error outranks a coincident clear.
    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            r_err_cnt  <= '0;
            r_err_intr <= 1'b0;
        end else if (w_err_evt) begin
            r_err_intr <= 1'b1;
            if (err_clr) begin
                r_err_cnt <= 8'd1;
            end else if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end else if (err_clr) begin
            r_err_cnt  <= '0;
            r_err_intr <= 1'b0;
        end
    end

    assign err_cnt  = r_err_cnt;
    assign err_intr = r_err_intr;

endmodule

// File: tb/tb_ahb_slave_decode_mux.sv
// Bench for ahb_slave_decode_mux: directed scenarios plus a random run, all
// checked against an address-range / owner / remaining-error-cycles model.
module tb_ahb_slave_decode_mux;

    localparam int unsigned SLV     = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned SEL_LSB = 16;
    localparam logic [31:0] BASE    = 32'h4000_0000;

    logic               hclk = 1'b0;
    logic               hrst_b;
    logic               hsel;
    logic [31:0]        haddr;
    logic [1:0]         htrans;
    logic               hwrite;
    logic [SLV-1:0]     s_hsel;
    logic [32*SLV-1:0]  s_hrdata;
    logic [SLV-1:0]     s_hready;
    logic [2*SLV-1:0]   s_hresp;
    logic [31:0]        hrdata;
    logic               hready;
    logic [1:0]         hresp;
    logic               err_clr;
    logic [7:0]         err_cnt;
    logic               err_intr;

    int errors = 0;
    int checks = 0;

    // Model: owner -1 = none, -2 = default slave, else slot number.
    int m_owner;
    int m_left;
    int m_cnt;
    bit m_intr;

    ahb_slave_decode_mux #(
        .SLV_NUM(SLV), .SEL_W(SEL_W), .SEL_LSB(SEL_LSB), .BASE(BASE)
    ) dut (
        .hclk(hclk), .hrst_b(hrst_b), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .s_hsel(s_hsel),
        .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp),
        .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .err_clr(err_clr), .err_cnt(err_cnt), .err_intr(err_intr)
    );

    always #5 hclk = ~hclk;

    function automatic int slot_of(input logic [31:0] a);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        if (off >= 0 && off < (longint'(SLV) << SEL_LSB)) return int'(off >> SEL_LSB);
        return -1;
    endfunction

    function automatic logic exp_hready();
        if (m_owner == -1) return 1'b1;
        if (m_owner == -2) return (m_left != 2);
        return s_hready[m_owner];
    endfunction

    function automatic logic [1:0] exp_hresp();
        if (m_owner == -1) return 2'b00;
        if (m_owner == -2) return 2'b01;
        return s_hresp[2*m_owner +: 2];
    endfunction

    function automatic logic [31:0] exp_hrdata();
        if (m_owner < 0) return 32'd0;
        return s_hrdata[32*m_owner +: 32];
    endfunction

    function automatic logic [SLV-1:0] exp_shsel();
        int s;
        logic [SLV-1:0] v;
        s = slot_of(haddr);
        v = '0;
        if (hsel && s >= 0) v[s] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_cnt = 0; m_intr = 1'b0;
    endtask

    task automatic drive(input logic sel, input logic [31:0] a, input logic [1:0] tr);
        hsel = sel; haddr = a; htrans = tr; hwrite = $urandom_range(1);
    endtask

    // One clock edge; the model consumes the inputs as they stand before the edge.
    task automatic advance();
        bit acc, req, ne;
        int sl;
        acc = exp_hready();
        sl  = slot_of(haddr);
        req = hsel && htrans[1];
        ne  = acc && req && (sl < 0);
        @(posedge hclk);
        #1;
        if (m_left > 0) m_left--;
        if (ne) begin
            m_left = 2;
            m_intr = 1'b1;
            m_cnt  = err_clr ? 1 : (m_cnt >= 255 ? 255 : m_cnt + 1);
        end else if (err_clr) begin
            m_cnt = 0; m_intr = 1'b0;
        end
        if (acc) m_owner = !req ? -1 : (sl >= 0 ? sl : -2);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (hready !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'd0) begin
            errors++; $display("FAIL reset_resp: got %b/%b/%h want 1/00/0", hready, hresp, hrdata); end
        checks++; if (err_cnt !== 8'd0 || err_intr !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %0d/%b want 0/0", err_cnt, err_intr); end
        @(posedge hclk); #1; hrst_b = 1'b1;
        model_reset();
        drive(1'b1, 32'h5000_0000, 2'b10);
        advance();
        drive(1'b0, 32'd0, 2'b00);
        #2;
        checks++; if (hready !== 1'b0 || err_cnt !== 8'd1) begin
            errors++; $display("FAIL err1_before_reset: got %b/%0d want 0/1", hready, err_cnt); end
        hrst_b = 1'b0;
        #1;
        checks++; if (hready !== 1'b1 || hresp !== 2'b00 || err_cnt !== 8'd0 || err_intr !== 1'b0) begin
            errors++; $display("FAIL async_reset: got %b/%b/%0d/%b want 1/00/0/0", hready, hresp, err_cnt, err_intr); end
        @(posedge hclk); #1; hrst_b = 1'b1;
        model_reset();
    endtask

    task automatic test_slot_read();
        s_hrdata[32 +: 32] = 32'hA5A5_0001;
        s_hready = '1; s_hresp = '0;
        drive(1'b1, 32'h4001_0004, 2'b10);
        #2;
        checks++; if (s_hsel !== 3'b010) begin
            errors++; $display("FAIL slot1_hsel: got %b want 010", s_hsel); end
        advance();
        drive(1'b0, 32'd0, 2'b00);
        #2;
        checks++; if (hrdata !== 32'hA5A5_0001 || hresp !== 2'b00 || hready !== 1'b1) begin
            errors++; $display("FAIL slot1_read: got %h/%b/%b want a5a50001/00/1", hrdata, hresp, hready); end
        advance();
    endtask

    task automatic test_wait_state();
        s_hrdata[0 +: 32]  = 32'h0000_AAAA;
        s_hrdata[64 +: 32] = 32'h2222_0002;
        drive(1'b1, 32'h4002_0010, 2'b10);
        advance();
        s_hready[2] = 1'b0;
        drive(1'b1, 32'h4000_0000, 2'b10);
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++; if (hready !== 1'b0 || hrdata !== 32'h2222_0002) begin
                errors++; $display("FAIL stall_%0d: got %b/%h want 0/22220002", k, hready, hrdata); end
            advance();
        end
        s_hready[2] = 1'b1;
        drive(1'b0, 32'd0, 2'b00);
        #2;
        checks++; if (hready !== 1'b1 || hrdata !== 32'h2222_0002) begin
            errors++; $display("FAIL stall_release: got %b/%h want 1/22220002", hready, hrdata); end
        advance();
        checks++; if (hrdata !== 32'd0 || hready !== 1'b1) begin
            errors++; $display("FAIL stall_addr_ignored: got %h/%b want 0/1", hrdata, hready); end
    endtask

    task automatic test_default_error();
        drive(1'b1, 32'h5000_0000, 2'b10);
        advance();
        drive(1'b0, 32'd0, 2'b00);
        #2;
        checks++; if (hready !== 1'b0 || hresp !== 2'b01 || hrdata !== 32'd0) begin
            errors++; $display("FAIL def_err1: got %b/%b/%h want 0/01/0", hready, hresp, hrdata); end
        advance();
        checks++; if (hready !== 1'b1 || hresp !== 2'b01) begin
            errors++; $display("FAIL def_err2: got %b/%b want 1/01", hready, hresp); end
        advance();
        checks++; if (hresp !== 2'b00 || err_cnt !== 8'd1 || err_intr !== 1'b1) begin
            errors++; $display("FAIL def_count: got %b/%0d/%b want 00/1/1", hresp, err_cnt, err_intr); end
    endtask

    task automatic test_back_to_back();
        err_clr = 1'b1;
        advance();
        err_clr = 1'b0;
        checks++; if (err_cnt !== 8'd0 || err_intr !== 1'b0) begin
            errors++; $display("FAIL clr_alone: got %0d/%b want 0/0", err_cnt, err_intr); end
        drive(1'b1, 32'h5000_0000, 2'b10);
        advance();
        drive(1'b1, 32'h4003_0000, 2'b10);
        #2;
        checks++; if (hready !== 1'b0 || hresp !== 2'b01 || s_hsel !== 3'b000) begin
            errors++; $display("FAIL b2b_err1a: got %b/%b/%b want 0/01/000", hready, hresp, s_hsel); end
        advance();
        checks++; if (hready !== 1'b1 || hresp !== 2'b01) begin
            errors++; $display("FAIL b2b_err2a: got %b/%b want 1/01", hready, hresp); end
        advance();
        drive(1'b0, 32'd0, 2'b00);
        #2;
        checks++; if (hready !== 1'b0 || hresp !== 2'b01) begin
            errors++; $display("FAIL b2b_err1b: got %b/%b want 0/01", hready, hresp); end
        advance();
        checks++; if (hready !== 1'b1 || hresp !== 2'b01) begin
            errors++; $display("FAIL b2b_err2b: got %b/%b want 1/01", hready, hresp); end
        advance();
        checks++; if (err_cnt !== 8'd2) begin
            errors++; $display("FAIL b2b_count: got %0d want 2", err_cnt); end
    endtask

    task automatic test_saturation_clear();
        drive(1'b1, 32'h6000_0000, 2'b10);
        repeat (600) advance();
        drive(1'b0, 32'd0, 2'b00);
        advance(); advance();
        checks++; if (err_cnt !== 8'hFF || err_intr !== 1'b1) begin
            errors++; $display("FAIL saturate: got %0d/%b want 255/1", err_cnt, err_intr); end
        drive(1'b1, 32'h7000_0000, 2'b10);
        err_clr = 1'b1;
        advance();
        err_clr = 1'b0;
        drive(1'b0, 32'd0, 2'b00);
        checks++; if (err_cnt !== 8'd1 || err_intr !== 1'b1) begin
            errors++; $display("FAIL clr_vs_err: got %0d/%b want 1/1", err_cnt, err_intr); end
        advance(); advance();
        err_clr = 1'b1;
        advance();
        err_clr = 1'b0;
        checks++; if (err_cnt !== 8'd0 || err_intr !== 1'b0) begin
            errors++; $display("FAIL clr_after: got %0d/%b want 0/0", err_cnt, err_intr); end
    endtask

    task automatic test_idle_trans();
        drive(1'b1, 32'h5000_0000, 2'b00);
        advance();
        drive(1'b1, 32'h5000_0004, 2'b01);
        advance();
        checks++; if (hready !== 1'b1 || hresp !== 2'b00 || err_cnt !== 8'd0 || err_intr !== 1'b0) begin
            errors++; $display("FAIL idle_unmapped: got %b/%b/%0d/%b want 1/00/0/0", hready, hresp, err_cnt, err_intr); end
        drive(1'b0, 32'd0, 2'b00);
        advance();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(3))
                0: a = BASE + ($urandom_range(SLV - 1) << SEL_LSB) + ($urandom & 32'h0000_FFFC);
                1: a = BASE + (32'd3 << SEL_LSB) + ($urandom & 32'h0000_FFFC);
                2: a = 32'h5000_0000 | ($urandom & 32'h0FFF_FFFC);
                default: a = $urandom;
            endcase
            drive($urandom_range(3) != 0, a, 2'($urandom_range(3)));
            for (int s = 0; s < int'(SLV); s++) begin
                s_hrdata[32*s +: 32] = $urandom;
                s_hready[s] = $urandom_range(3) != 0;
                s_hresp[2*s +: 2] = {1'b0, 1'($urandom_range(4) == 0)};
            end
            err_clr = $urandom_range(15) == 0;
            #2;
            checks++; if (s_hsel !== exp_shsel()) begin
                errors++; $display("FAIL rnd_shsel @%0d: got %b want %b", n, s_hsel, exp_shsel()); end
            checks++; if (hready !== exp_hready() || hresp !== exp_hresp()) begin
                errors++; $display("FAIL rnd_resp @%0d: got %b/%b want %b/%b", n, hready, hresp, exp_hready(), exp_hresp()); end
            checks++; if (hrdata !== exp_hrdata()) begin
                errors++; $display("FAIL rnd_hrdata @%0d: got %h want %h", n, hrdata, exp_hrdata()); end
            checks++; if (err_cnt !== 8'(m_cnt) || err_intr !== m_intr) begin
                errors++; $display("FAIL rnd_err @%0d: got %0d/%b want %0d/%b", n, err_cnt, err_intr, m_cnt, m_intr); end
            advance();
        end
        err_clr = 1'b0;
    endtask

    initial begin
        hrst_b = 1'b0; err_clr = 1'b0;
        s_hrdata = '0; s_hready = '1; s_hresp = '0;
        drive(1'b0, 32'd0, 2'b00);
        model_reset();
        @(posedge hclk); #1;
        test_reset();
        test_slot_read();
        test_wait_state();
        test_default_error();
        test_back_to_back();
        test_saturation_clear();
        test_idle_trans();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
